// File: rtl/sevenseg_scan_ctrl_if.sv
// Display-side bundle of the seven-segment scan controller: enable/value in,
// decoder nibble, digit selects and status out.
interface sevenseg_scan_ctrl_if #(
    parameter int num_digits = 4
);
    logic                      in_enable;
    logic [num_digits*4-1:0]   in_value;
    logic [3:0]                out_digit;
    logic [num_digits-1:0]     out_digit_sel;
    logic [2:0]                out_idx;
    logic                      out_frame;
    logic                      out_busy;

    // Datapath side: drives enable/value, observes the scan outputs.
    modport master (
        output in_enable, in_value,
        input  out_digit, out_digit_sel, out_idx, out_frame, out_busy
    );

    // Controller side.
    modport slave (
        input  in_enable, in_value,
        output out_digit, out_digit_sel, out_idx, out_frame, out_busy
    );
endinterface

// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit seven-segment display.
// Each slot shows one snapshot nibble: a blanking interval first (selects off,
// decoder settling), then the digit select. The input value is captured once
// per frame so a frame never mixes two values.
module sevenseg_scan_ctrl #(
    parameter int num_digits     = 4,
    parameter int clk_div        = 1000,
    parameter int blank_cycles   = 8,
    parameter int sel_active_low = 0,
    parameter int lz_blank       = 1
) (
    input logic                 in_clk,
    input logic                 in_rst,
    sevenseg_scan_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    localparam int              PW         = (clk_div > 1) ? $clog2(clk_div) : 1;
    localparam logic [PW-1:0]   P_LAST     = PW'(clk_div - 1);
    localparam logic [PW-1:0]   P_BLANK    = PW'(blank_cycles);
    localparam logic [2:0]      LAST_IDX   = 3'(num_digits - 1);
    localparam state_t          SLOT_START = (blank_cycles == 0) ? SHOW : BLANK;

    state_t                    state, state_next;
    logic [PW-1:0]             presc, presc_next;
    logic [2:0]                idx, idx_next;
    logic [num_digits*4-1:0]   snap, snap_next;
    logic                      frame_q, frame_next;

    logic [num_digits-1:0]     blanked;
    logic [num_digits-1:0]     sel_raw;
    logic                      tail_zero;

    // State register plus prescaler, digit index, snapshot and frame flag.
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            state   <= IDLE;
            presc   <= '0;
            idx     <= '0;
            snap    <= '0;
            frame_q <= 1'b0;
        end else begin
            state   <= state_next;
            presc   <= presc_next;
            idx     <= idx_next;
            snap    <= snap_next;
            frame_q <= frame_next;
        end
    end

    // Next-state: slot sequencing, snapshot capture at frame start, enable
    // sampled only at slot boundaries so the running slot always completes.
    always_comb begin
        state_next = state;
        presc_next = presc;
        idx_next   = idx;
        snap_next  = snap;
        frame_next = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_enable) begin
                    snap_next  = bus.in_value;
                    idx_next   = '0;
                    presc_next = '0;
                    state_next = SLOT_START;
                    frame_next = 1'b1;
                end
            end
            default: begin
                if (presc == P_LAST) begin
                    presc_next = '0;
                    if (idx == LAST_IDX) begin
                        idx_next  = '0;
                        snap_next = bus.in_value;
                    end else begin
                        idx_next = idx + 3'd1;
                    end
                    if (bus.in_enable) begin
                        state_next = SLOT_START;
                        frame_next = (idx == LAST_IDX);
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    presc_next = presc + 1'b1;
                    // Blanking ends when the prescaler reaches blank_cycles.
                    if (state == BLANK && presc_next == P_BLANK) begin
                        state_next = SHOW;
                    end
                end
            end
        endcase
    end

    // Outputs: nibble mux, leading-zero mask, one-hot select with polarity.
    always_comb begin
        bus.out_digit = '0;
        for (int unsigned k = 0; k < num_digits; k++) begin
            if (idx == 3'(k)) begin
                bus.out_digit = snap[k*4 +: 4];
            end
        end

        // Walk from the most significant digit down; a digit is blanked while
        // every nibble from it upwards is zero. Digit 0 is always shown.
        tail_zero = 1'b1;
        blanked   = '0;
        for (int unsigned i = 0; i < num_digits; i++) begin
            tail_zero = tail_zero & (snap[(num_digits-1-i)*4 +: 4] == 4'h0);
            if (lz_blank != 0 && (num_digits - 1 - i) != 0 && tail_zero) begin
                blanked[num_digits-1-i] = 1'b1;
            end
        end

        sel_raw = '0;
        for (int unsigned k = 0; k < num_digits; k++) begin
            sel_raw[k] = (state == SHOW) && (idx == 3'(k)) && !blanked[k];
        end

        bus.out_digit_sel = (sel_active_low != 0) ? ~sel_raw : sel_raw;
        bus.out_idx       = idx;
        bus.out_frame     = frame_q;
        bus.out_busy      = (state != IDLE);
    end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Bench for sevenseg_scan_ctrl: four instances (main, no leading-zero
// blanking, zero blanking interval, single active-low digit) checked against
// a frame-time reference model.
module tb_sevenseg_scan_ctrl;

    localparam int CD = 10;

    logic in_clk;
    logic in_rst;

    logic        en      [4];
    logic [31:0] val     [4];
    logic [3:0]  o_digit [4];
    logic [7:0]  o_sel   [4];
    logic [2:0]  o_idx   [4];
    logic        o_frame [4];
    logic        o_busy  [4];

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: a frame-time counter t (0 .. nd*CD-1) per instance.
    bit          m_active [4];
    int          m_t      [4];
    logic [31:0] m_snap   [4];
    bit          m_frame  [4];
    bit          m_fresh  [4];

    sevenseg_scan_ctrl_if #(.num_digits(4)) bus0 ();
    sevenseg_scan_ctrl_if #(.num_digits(4)) bus1 ();
    sevenseg_scan_ctrl_if #(.num_digits(4)) bus2 ();
    sevenseg_scan_ctrl_if #(.num_digits(1)) bus3 ();

    sevenseg_scan_ctrl #(.num_digits(4), .clk_div(CD), .blank_cycles(2),
        .sel_active_low(0), .lz_blank(1)) dut0 (.in_clk(in_clk), .in_rst(in_rst), .bus(bus0));
    sevenseg_scan_ctrl #(.num_digits(4), .clk_div(CD), .blank_cycles(2),
        .sel_active_low(0), .lz_blank(0)) dut1 (.in_clk(in_clk), .in_rst(in_rst), .bus(bus1));
    sevenseg_scan_ctrl #(.num_digits(4), .clk_div(CD), .blank_cycles(0),
        .sel_active_low(0), .lz_blank(1)) dut2 (.in_clk(in_clk), .in_rst(in_rst), .bus(bus2));
    sevenseg_scan_ctrl #(.num_digits(1), .clk_div(CD), .blank_cycles(2),
        .sel_active_low(1), .lz_blank(1)) dut3 (.in_clk(in_clk), .in_rst(in_rst), .bus(bus3));

    assign bus0.in_enable = en[0];
    assign bus1.in_enable = en[1];
    assign bus2.in_enable = en[2];
    assign bus3.in_enable = en[3];
    assign bus0.in_value  = val[0][15:0];
    assign bus1.in_value  = val[1][15:0];
    assign bus2.in_value  = val[2][15:0];
    assign bus3.in_value  = val[3][3:0];

    assign o_digit[0] = bus0.out_digit;
    assign o_digit[1] = bus1.out_digit;
    assign o_digit[2] = bus2.out_digit;
    assign o_digit[3] = bus3.out_digit;
    assign o_sel[0]   = 8'(bus0.out_digit_sel);
    assign o_sel[1]   = 8'(bus1.out_digit_sel);
    assign o_sel[2]   = 8'(bus2.out_digit_sel);
    assign o_sel[3]   = 8'(bus3.out_digit_sel);
    assign o_idx[0]   = bus0.out_idx;
    assign o_idx[1]   = bus1.out_idx;
    assign o_idx[2]   = bus2.out_idx;
    assign o_idx[3]   = bus3.out_idx;
    assign o_frame[0] = bus0.out_frame;
    assign o_frame[1] = bus1.out_frame;
    assign o_frame[2] = bus2.out_frame;
    assign o_frame[3] = bus3.out_frame;
    assign o_busy[0]  = bus0.out_busy;
    assign o_busy[1]  = bus1.out_busy;
    assign o_busy[2]  = bus2.out_busy;
    assign o_busy[3]  = bus3.out_busy;

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    function automatic int cfg_nd(int i);   return (i == 3) ? 1 : 4; endfunction
    function automatic int cfg_bc(int i);   return (i == 2) ? 0 : 2; endfunction
    function automatic int cfg_sal(int i);  return (i == 3) ? 1 : 0; endfunction
    function automatic int cfg_lz(int i);   return (i == 1) ? 0 : 1; endfunction
    function automatic logic [31:0] cfg_msk(int i);
        return (cfg_nd(i) == 4) ? 32'h0000_FFFF : 32'h0000_000F;
    endfunction

    // Expected {busy, frame, sel[7:0], idx[2:0], digit[3:0]} from the model.
    function automatic logic [16:0] exp_vec(int i);
        int          idx;
        int          p;
        logic [31:0] up;
        logic [7:0]  s;
        logic [3:0]  d;
        logic [2:0]  ix;
        s  = '0;
        d  = '0;
        ix = '0;
        if (m_active[i]) begin
            idx = m_t[i] / CD;
            p   = m_t[i] % CD;
            up  = m_snap[i] >> (4 * idx);
            d   = up[3:0];
            ix  = 3'(idx);
            if (p >= cfg_bc(i) && !(cfg_lz(i) != 0 && idx > 0 && up == 0))
                s = 8'(1) << idx;
        end
        if (cfg_sal(i) != 0) s = ~s & 8'((1 << cfg_nd(i)) - 1);
        return {m_active[i], m_frame[i], s, ix, d};
    endfunction

    // idx/digit are only defined while scanning or before the first enable.
    function automatic logic [16:0] care_vec(int i);
        return (m_active[i] || m_fresh[i]) ? 17'h1FFFF : 17'h1FF80;
    endfunction

    function automatic logic [16:0] obs_vec(int i);
        return {o_busy[i], o_frame[i], o_sel[i], o_idx[i], o_digit[i]};
    endfunction

    // Reference model advance on each clock edge; asynchronous reset.
    always @(posedge in_clk or negedge in_rst) begin
        for (int i = 0; i < 4; i++) begin
            bit          a;
            int          t;
            logic [31:0] sn;
            bit          f;
            bit          fr;
            a  = m_active[i];
            t  = m_t[i];
            sn = m_snap[i];
            f  = 1'b0;
            fr = m_fresh[i];
            if (!in_rst) begin
                a = 1'b0; t = 0; sn = '0; fr = 1'b1;
            end else if (!a) begin
                if (en[i]) begin
                    a = 1'b1; t = 0; sn = val[i] & cfg_msk(i); f = 1'b1; fr = 1'b0;
                end
            end else if (t % CD == CD - 1) begin
                if (t == cfg_nd(i) * CD - 1) begin
                    t = 0; sn = val[i] & cfg_msk(i); f = en[i];
                end else begin
                    t = t + 1;
                end
                if (!en[i]) a = 1'b0;
            end else begin
                t = t + 1;
            end
            m_active[i] <= a;
            m_t[i]      <= t;
            m_snap[i]   <= sn;
            m_frame[i]  <= f;
            m_fresh[i]  <= fr;
        end
    end

    task automatic test_reset;
        repeat (3) @(negedge in_clk);
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (obs_vec(i) !== {2'b00, (i == 3) ? 8'h01 : 8'h00, 7'h00}) begin
                n_bad++;
                $display("FAIL reset_hold[%0d] got %h want %h", i, obs_vec(i),
                         {2'b00, (i == 3) ? 8'h01 : 8'h00, 7'h00});
            end
        end
        in_rst = 1'b1;
        @(negedge in_clk);
    endtask

    task automatic test_basic;
        int fr0 = 0;
        int fr3 = 0;
        for (int i = 0; i < 4; i++) begin val[i] = 32'h1234; en[i] = 1'b1; end
        @(negedge in_clk);
        n_vec++;
        if (o_digit[0] !== 4'h4 || o_frame[0] !== 1'b1 || o_sel[0] !== 8'h00) begin
            n_bad++;
            $display("FAIL basic_first digit=%h frame=%b sel=%b want 4/1/00000000",
                     o_digit[0], o_frame[0], o_sel[0]);
        end
        n_vec++;
        if (o_sel[2] !== 8'h01 || o_sel[3] !== 8'h01) begin
            n_bad++;
            $display("FAIL basic_corner_sel blank0=%b lowsel=%b want 1/1", o_sel[2], o_sel[3]);
        end
        for (int c = 0; c < 80; c++) begin
            for (int i = 0; i < 4; i++) begin
                n_vec++;
                if ((obs_vec(i) & care_vec(i)) !== (exp_vec(i) & care_vec(i))) begin
                    n_bad++;
                    $display("FAIL basic[%0d] c=%0d got %h want %h", i, c, obs_vec(i), exp_vec(i));
                end
            end
            fr0 += int'(o_frame[0]);
            fr3 += int'(o_frame[3]);
            @(negedge in_clk);
        end
        n_vec++;
        if (fr0 != 2 || fr3 != 8) begin
            n_bad++;
            $display("FAIL basic_frames got %0d/%0d want 2/8", fr0, fr3);
        end
    endtask

    task automatic test_anti_tear;
        int w = 0;
        while (m_t[0] != 15 && w < 200) begin @(negedge in_clk); w++; end
        if (m_t[0] != 15) begin
            n_vec++; n_bad++;
            $display("FAIL anti_tear_wait got t=%0d want 15", m_t[0]);
        end
        for (int i = 0; i < 4; i++) val[i] = 32'hABCD;
        for (int c = 0; c < 60; c++) begin
            for (int i = 0; i < 4; i++) begin
                n_vec++;
                if ((obs_vec(i) & care_vec(i)) !== (exp_vec(i) & care_vec(i))) begin
                    n_bad++;
                    $display("FAIL anti_tear[%0d] c=%0d got %h want %h", i, c, obs_vec(i), exp_vec(i));
                end
            end
            if (c == 5 || c == 15 || c == 25 || c == 35) begin
                logic [3:0] want;
                want = (c == 5) ? 4'h2 : (c == 15) ? 4'h1 : (c == 25) ? 4'hD : 4'hC;
                n_vec++;
                if (o_digit[0] !== want) begin
                    n_bad++;
                    $display("FAIL anti_tear_digit c=%0d got %h want %h", c, o_digit[0], want);
                end
            end
            @(negedge in_clk);
        end
    endtask

    task automatic test_leading_zero;
        logic [31:0] pat [2];
        logic [7:0]  acc [3];
        pat[0] = 32'h0050;
        pat[1] = 32'h0000;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) val[i] = pat[k];
            for (int i = 0; i < 3; i++) acc[i] = '0;
            for (int c = 0; c < 81; c++) begin
                for (int i = 0; i < 4; i++) begin
                    n_vec++;
                    if ((obs_vec(i) & care_vec(i)) !== (exp_vec(i) & care_vec(i))) begin
                        n_bad++;
                        $display("FAIL lz[%0d] c=%0d got %h want %h", i, c, obs_vec(i), exp_vec(i));
                    end
                end
                if (c > 40) for (int i = 0; i < 3; i++) acc[i] = acc[i] | o_sel[i];
                @(negedge in_clk);
            end
            n_vec++;
            if (acc[0] !== ((k == 0) ? 8'h03 : 8'h01) || acc[1] !== 8'h0F ||
                acc[2] !== ((k == 0) ? 8'h03 : 8'h01)) begin
                n_bad++;
                $display("FAIL lz_selects pat=%h got %b/%b/%b", pat[k], acc[0], acc[1], acc[2]);
            end
        end
    endtask

    task automatic test_disable;
        int w = 0;
        for (int i = 0; i < 4; i++) val[i] = 32'h1234;
        while (m_t[0] != 24 && w < 200) begin @(negedge in_clk); w++; end
        if (m_t[0] != 24) begin
            n_vec++; n_bad++;
            $display("FAIL disable_wait got t=%0d want 24", m_t[0]);
        end
        en[0] = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge in_clk);
            for (int i = 0; i < 4; i++) begin
                n_vec++;
                if ((obs_vec(i) & care_vec(i)) !== (exp_vec(i) & care_vec(i))) begin
                    n_bad++;
                    $display("FAIL disable[%0d] c=%0d got %h want %h", i, c, obs_vec(i), exp_vec(i));
                end
            end
            if (c == 5) begin
                n_vec++;
                if (o_busy[0] !== 1'b1 || o_idx[0] !== 3'd2) begin
                    n_bad++;
                    $display("FAIL disable_slot_end busy=%b idx=%0d want 1/2", o_busy[0], o_idx[0]);
                end
            end
            if (c == 6) begin
                n_vec++;
                if (o_busy[0] !== 1'b0 || o_sel[0] !== 8'h00) begin
                    n_bad++;
                    $display("FAIL disable_idle busy=%b sel=%b want 0/00000000", o_busy[0], o_sel[0]);
                end
            end
        end
        val[0] = 32'h9876;
        en[0]  = 1'b1;
        @(negedge in_clk);
        n_vec++;
        if (o_idx[0] !== 3'd0 || o_frame[0] !== 1'b1 || o_digit[0] !== 4'h6) begin
            n_bad++;
            $display("FAIL reenable idx=%0d frame=%b digit=%h want 0/1/6", o_idx[0], o_frame[0], o_digit[0]);
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge in_clk);
            for (int i = 0; i < 4; i++) begin
                n_vec++;
                if ((obs_vec(i) & care_vec(i)) !== (exp_vec(i) & care_vec(i))) begin
                    n_bad++;
                    $display("FAIL reenable[%0d] c=%0d got %h want %h", i, c, obs_vec(i), exp_vec(i));
                end
            end
        end
    endtask

    task automatic test_reset_async;
        int w = 0;
        while (m_t[0] != 5 && w < 200) begin @(negedge in_clk); w++; end
        if (m_t[0] != 5) begin
            n_vec++; n_bad++;
            $display("FAIL reset_async_wait got t=%0d want 5", m_t[0]);
        end
        #2;
        in_rst = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (obs_vec(i) !== {2'b00, (i == 3) ? 8'h01 : 8'h00, 7'h00}) begin
                n_bad++;
                $display("FAIL reset_async[%0d] got %h want %h", i, obs_vec(i),
                         {2'b00, (i == 3) ? 8'h01 : 8'h00, 7'h00});
            end
        end
        @(negedge in_clk);
        in_rst = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge in_clk);
            for (int i = 0; i < 4; i++) begin
                n_vec++;
                if ((obs_vec(i) & care_vec(i)) !== (exp_vec(i) & care_vec(i))) begin
                    n_bad++;
                    $display("FAIL after_reset[%0d] c=%0d got %h want %h", i, c, obs_vec(i), exp_vec(i));
                end
            end
        end
    endtask

    task automatic test_random;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 4; i++) begin
                n_vec++;
                if ((obs_vec(i) & care_vec(i)) !== (exp_vec(i) & care_vec(i))) begin
                    n_bad++;
                    $display("FAIL random[%0d] c=%0d got %h want %h", i, c, obs_vec(i), exp_vec(i));
                end
            end
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 29) == 0) en[i] = ~en[i];
                case ($urandom_range(0, 3))
                    0:       val[i] = $urandom;
                    1:       val[i] = $urandom & 32'h0000_00FF;
                    2:       val[i] = $urandom & 32'h0000_000F;
                    default: val[i] = '0;
                endcase
            end
            @(negedge in_clk);
        end
    endtask

    initial begin
        in_rst = 1'b0;
        for (int i = 0; i < 4; i++) begin en[i] = 1'b0; val[i] = '0; end
        test_reset;
        test_basic;
        test_anti_tear;
        test_leading_zero;
        test_disable;
        test_reset_async;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sevenseg_scan_ctrl.md
Name: sevenseg_scan_ctrl

Overview:
- Time-multiplexed scan controller for an N-digit common-select seven-segment display.
- Shares one sevenseg decoder between all digits.
- Per slot, it presents one 4-bit nibble to the decoder and drives the matching one-hot digit select.
- A blanking interval at the start of each slot suppresses ghosting; the input value is snapshotted once per frame so the display never tears.
- Sits between counter-type datapaths (driving in_value) and the sevenseg decoder / board pins.

Parameters:
- num_digits, 4: digits scanned; legal 1..8.
- clk_div, 1000: clock cycles per digit slot; legal >= 2.
- blank_cycles, 8: cycles at slot start with all selects inactive; legal 0..clk_div-1.
- sel_active_low, 0: 1 = out_digit_sel asserted-low.
- lz_blank, 1: 1 = leading-zero blanking enabled.

Ports:
- in_clk, in, 1: clock.
- in_rst, in, 1: asynchronous, active-low reset.
- in_enable, in, 1: scanning enable.
- in_value, in, num_digits*4: packed nibbles; digit 0 = bits [3:0].
- out_digit, out, 4: nibble routed to the sevenseg decoder.
- out_digit_sel, out, num_digits: one-hot digit select; polarity per sel_active_low.
- out_idx, out, 3: current digit index.
- out_frame, out, 1: one-cycle pulse in the first cycle of each frame.
- out_busy, out, 1: high while not IDLE.

Behaviour:

Reset (in_rst=0, asynchronous):
- State = IDLE.
- Prescaler, out_idx, out_digit, out_frame, out_busy and the snapshot register all = 0.
- out_digit_sel = all inactive (0, or all-ones if sel_active_low).

States: IDLE, BLANK, SHOW.

IDLE:
- Selects inactive, out_busy=0.
- On a rising edge with in_enable=1: snapshot <= in_value, idx <= 0, prescaler <= 0, enter BLANK (or SHOW if blank_cycles=0).
- The first cycle after that edge has out_frame=1.

Slot timing (prescaler p = 0..clk_div-1):
- out_digit = snapshot nibble[idx]; it is valid from p=0 of the slot, so the decoder settles during BLANK.
- p < blank_cycles: BLANK, selects inactive.
- p >= blank_cycles: SHOW, select bit idx active unless the digit is lz-blanked.
- At p=clk_div-1, the next edge starts a new slot:
  - p <= 0.
  - If idx < num_digits-1: idx <= idx+1.
  - Otherwise: idx <= 0, snapshot <= in_value, out_frame=1 for the first cycle of the new frame.
- Frame period = num_digits*clk_div cycles exactly; no gap cycles.

Leading-zero blanking (lz_blank=1):
- Digit k is blanked (select held inactive through SHOW) iff k>0 and snapshot nibbles k..num_digits-1 are all zero.
- Digit 0 is never blanked.
- Evaluated on the snapshot, not the live input.

in_enable deassertion:
- Sampled only at a slot boundary (edge after p=clk_div-1). If 0 there, enter IDLE; selects go inactive that cycle.
- The current slot always completes.
- Re-enable restarts at digit 0 with a fresh snapshot and out_frame pulse.

in_enable held 1 continuously: free-running scan, idx wraps num_digits-1 -> 0.

in_value changes: ignored except at the snapshot edges.

Reset mid-slot: immediate return to the reset values, no clock edge required. After release, the controller starts from IDLE.

Invariant: at most one select bit is ever active.

Widths: prescaler = clog2(clk_div) bits; idx zero-extended to 3 bits.

Test Plan (num_digits=4, clk_div=10, blank_cycles=2, sel_active_low=0, lz_blank=1 unless stated):
1. Reset: hold in_rst=0 with clock toggling, then pulse in_rst low mid-SHOW -> sel=0000, idx=0, out_frame=0, out_busy=0, cleared immediately without a clock edge.
2. Basic scan: in_value=16'h1234, enable -> out_frame pulses every 40 cycles.
   - Slot 0: out_digit=4; sel=0000 for p=0..1, then 0001 for p=2..9.
   - Slots 1..3: digits 3,2,1 with sel 0010,0100,1000.
   - Then wraps to idx 0.
3. Anti-tearing: change in_value to 16'hABCD during slot 1 -> the rest of the frame shows 3,2,1; the next frame shows D,C,B,A.
4. Leading zeros:
   - in_value=16'h0050 -> digits 3,2 have sel=0000 throughout; digit 1 shows 5, digit 0 shows 0.
   - in_value=16'h0000 -> only digit 0 is ever selected.
   - With lz_blank=0, all four digits are selected.
5. Disable: deassert in_enable at p=4 of slot 2 -> slot 2 runs to p=9, then IDLE with sel=0000 and out_busy=0. Re-enable -> idx=0, out_frame=1, fresh snapshot.
6. Parameter corners:
   - blank_cycles=0 -> select active from p=0.
   - num_digits=1, sel_active_low=1 -> out_digit_sel=0 in SHOW, 1 otherwise; out_frame every 10 cycles.
